// File: rtl/core_inst_sequencer.sv
// Instruction-bus initiator: one start pulse runs kernel load, activation stream and pmem drain for a tile pass.
// Optional SEQ_PERF_CNT_EN adds a 32-bit cycle_cnt output counting busy cycles of the last pass.
module core_inst_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [cnt_bw-1:0]  num_act,
  input  logic               ofifo_valid,
  output logic [35:0]        inst,
  output logic               busy,
  output logic               done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KREAD  = 3'd1;
  localparam logic [2:0] S_KPUSH  = 3'd2;
  localparam logic [2:0] S_AREAD  = 3'd3;
  localparam logic [2:0] S_ADRAIN = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [35:0]       IDLE_WORD  = 36'h1800C0000;
  localparam logic [cnt_bw-1:0] KREAD_LAST = cnt_bw'(row - 1);
  localparam logic [cnt_bw-1:0] FLUSH_LAST = cnt_bw'(row + col - 1);

  logic [2:0]         state, nxt_state;
  logic [cnt_bw-1:0]  cnt, nxt_cnt;
  logic [cnt_bw-1:0]  rd_cnt, nxt_rd_cnt;
  logic [cnt_bw-1:0]  wr_cnt, nxt_wr_cnt;
  logic [cnt_bw-1:0]  num_act_q;
  logic [addr_bw-1:0] w_base_q, a_base_q, p_base_q;
  logic [addr_bw-1:0] w_src;
  logic [35:0]        nxt_inst;
  logic               rd_take;

  // The state register names the phase of the word being driven; nxt_inst is the word for nxt_state.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_rd_cnt = rd_cnt;
    nxt_wr_cnt = wr_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state  = S_KREAD;
          nxt_cnt    = '0;
          nxt_rd_cnt = '0;
          nxt_wr_cnt = '0;
        end
      end
      S_KREAD: begin
        if (cnt == KREAD_LAST) begin
          nxt_state = S_KPUSH;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_KPUSH: begin
        if (cnt == FLUSH_LAST) begin
          nxt_state = (num_act_q == '0) ? S_DONE : S_AREAD;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_AREAD: begin
        if (cnt == num_act_q - 1'b1) begin
          nxt_state = S_ADRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_ADRAIN: begin
        if (cnt == FLUSH_LAST) begin
          nxt_state = S_DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (wr_cnt == num_act_q && !inst[6]) nxt_state = S_DONE;
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    // Reads stop at num_act so a still-valid OFIFO is never over-drained.
    rd_take = (nxt_state == S_DRAIN) && ofifo_valid && (rd_cnt != num_act_q);
    if (rd_take) nxt_rd_cnt = rd_cnt + 1'b1;
    if (inst[6]) nxt_wr_cnt = wr_cnt + 1'b1;

    w_src    = (state == S_IDLE) ? w_base : w_base_q;
    nxt_inst = IDLE_WORD;
    case (nxt_state)
      S_KREAD: begin
        nxt_inst[19]   = 1'b0;
        nxt_inst[17:7] = 11'(w_src + addr_bw'(nxt_cnt));
      end
      S_KPUSH: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[0] = 1'b1;
      end
      S_AREAD: begin
        nxt_inst[19]   = 1'b0;
        nxt_inst[17:7] = 11'(a_base_q + addr_bw'(nxt_cnt));
        nxt_inst[3]    = 1'b1;
        nxt_inst[1]    = 1'b1;
      end
      S_ADRAIN: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[1] = 1'b1;
      end
      S_DRAIN: begin
        nxt_inst[35] = 1'b1;
        nxt_inst[6]  = rd_take;
      end
      default: ;
    endcase

    // SRAM read data lands one cycle later, and each OFIFO row is written to pmem one cycle after its read.
    nxt_inst[2] = ~inst[19];
    if (inst[6]) begin
      nxt_inst[32]    = 1'b0;
      nxt_inst[31]    = 1'b0;
      nxt_inst[30:20] = 11'(p_base_q + addr_bw'(wr_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      num_act_q <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      p_base_q  <= '0;
      inst      <= IDLE_WORD;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      rd_cnt <= nxt_rd_cnt;
      wr_cnt <= nxt_wr_cnt;
      inst   <= nxt_inst;
      busy   <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      done   <= (nxt_state == S_DONE);
      if (state == S_IDLE && start) begin
        num_act_q <= num_act;
        w_base_q  <= w_base;
        a_base_q  <= a_base;
        p_base_q  <= p_base;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
